// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-client SDRAM arbiter: FSM states, client index, timeout fill word.
package sdram_arb_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DONE} arb_state_t;

   typedef enum logic {CLI0, CLI1} client_t;

   localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/sdram_arb_rr.sv
// Grant decision for the arbiter: client 0 has priority, and a pending client 1
// wins once after STARVE_MAX back-to-back client-0 grants.
module sdram_arb_rr
   import sdram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    grant_en,
   input  logic    c0_req,
   input  logic    c1_req,
   output logic    grant_valid,
   output client_t grant_client
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve;
   logic          starved;

   assign starved = (starve == CW'(STARVE_MAX));

   always_comb begin
      grant_valid  = grant_en && (c0_req || c1_req);
      grant_client = (c1_req && (!c0_req || starved)) ? CLI1 : CLI0;
   end

   // Only client-0 grants made while client 1 is waiting count towards starvation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve <= '0;
      end else if (grant_valid) begin
         if (grant_client == CLI1)
            starve <= '0;
         else if (c1_req && !starved)
            starve <= starve + 1'b1;
      end
   end

endmodule

// File: rtl/sdram_arb.sv
// Two-client arbiter and req/ack-to-strobe adapter in front of the SDRAM controller.
// Optional watchdog on the controller ready line: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int AW = 24,
   parameter int DW = 16,
   parameter int STARVE_MAX = 4
`ifdef SDRAM_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT = 255
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c0_req,
   input  logic [AW-1:0] c0_addr,
   output logic          c0_ack,
   output logic [DW-1:0] c0_rdata,
   input  logic          c1_req,
   input  logic          c1_we,
   input  logic [AW-1:0] c1_addr,
   input  logic [DW-1:0] c1_wdata,
   input  logic [1:0]    c1_be,
   output logic          c1_ack,
   output logic [DW-1:0] c1_rdata,
   output logic [AW-1:0] sd_addr,
   output logic [DW-1:0] sd_din,
   output logic [1:0]    sd_wtbt,
   output logic          sd_we,
   output logic          sd_rd,
   input  logic [DW-1:0] sd_dout,
   input  logic          sd_ready,
   output logic          err
);

   arb_state_t    state;
   client_t       owner;
   logic          wr_op;
   logic          grant_en;
   logic          grant_valid;
   client_t       grant_client;
   logic          complete;
   logic          capture;
   logic          wd_fire;
   logic [DW-1:0] done_data;

   // Holding off while ready is low also covers controller power-up/init.
   assign grant_en = (state == IDLE) && sd_ready;

   sdram_arb_rr #(.STARVE_MAX(STARVE_MAX)) u_rr (
      .clk          (clk),
      .reset        (reset),
      .grant_en     (grant_en),
      .c0_req       (c0_req),
      .c1_req       (c1_req),
      .grant_valid  (grant_valid),
      .grant_client (grant_client)
   );

`ifdef SDRAM_ARB_TIMEOUT_EN
   logic [7:0] wdog;

   assign wd_fire = (state == WAIT) && !sd_ready && (wdog == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog <= '0;
         err  <= 1'b0;
      end else begin
         wdog <= (state == WAIT) ? wdog + 1'b1 : '0;
         if (wd_fire)
            err <= 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
   assign err     = 1'b0;
`endif

   // A ready seen in GUARD is a held-data hit; a write must still see ready in WAIT.
   always_comb begin
      complete  = 1'b0;
      done_data = wd_fire ? DW'(TIMEOUT_DATA) : sd_dout;
      case (state)
         GUARD:   complete = sd_ready && !wr_op;
         WAIT:    complete = sd_ready || wd_fire;
         default: complete = 1'b0;
      endcase
      capture = complete && (!wr_op || wd_fire);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= CLI0;
         wr_op    <= 1'b0;
         sd_addr  <= '0;
         sd_din   <= '0;
         sd_wtbt  <= '0;
         sd_we    <= 1'b0;
         sd_rd    <= 1'b0;
         c0_ack   <= 1'b0;
         c1_ack   <= 1'b0;
         c0_rdata <= '0;
         c1_rdata <= '0;
      end else begin
         sd_we  <= 1'b0;
         sd_rd  <= 1'b0;
         c0_ack <= 1'b0;
         c1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner <= grant_client;
                  if (grant_client == CLI1) begin
                     wr_op   <= c1_we;
                     sd_addr <= c1_addr;
                     sd_din  <= c1_wdata;
                     sd_wtbt <= c1_be;
                     sd_we   <= c1_we;
                     sd_rd   <= !c1_we;
                  end else begin
                     wr_op   <= 1'b0;
                     sd_addr <= c0_addr;
                     sd_din  <= '0;
                     sd_wtbt <= 2'b11;
                     sd_rd   <= 1'b1;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: state <= GUARD;
            GUARD, WAIT: begin
               if (complete) begin
                  // ack and rdata are raised on entry so they are valid during DONE
                  state <= DONE;
                  if (owner == CLI0) begin
                     c0_ack <= 1'b1;
                     if (capture) c0_rdata <= done_data;
                  end else begin
                     c1_ack <= 1'b1;
                     if (capture) c1_rdata <= done_data;
                  end
               end else begin
                  state <= WAIT;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: directed transactions against a small controller model.
module tb_sdram_arb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c0_req = 1'b0;
   logic [23:0] c0_addr = '0;
   logic        c0_ack;
   logic [15:0] c0_rdata;
   logic        c1_req = 1'b0;
   logic        c1_we = 1'b0;
   logic [23:0] c1_addr = '0;
   logic [15:0] c1_wdata = '0;
   logic [1:0]  c1_be = '0;
   logic        c1_ack;
   logic [15:0] c1_rdata;
   logic [23:0] sd_addr;
   logic [15:0] sd_din;
   logic [1:0]  sd_wtbt;
   logic        sd_we;
   logic        sd_rd;
   logic [15:0] sd_dout = '0;
   logic        sd_ready = 1'b0;
   logic        err;

   sdram_arb dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_be(c1_be), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
      .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt), .sd_we(sd_we),
      .sd_rd(sd_rd), .sd_dout(sd_dout), .sd_ready(sd_ready), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  wtbt;
   } strb_t;

   typedef struct {
      logic        cli;
      logic [15:0] data;
      logic        rd;
   } ack_t;

   strb_t strb_q[$];
   ack_t  ack_q[$];

   int errors = 0, checks = 0, cyc = 0;
   int nstrobe = 0, nack0 = 0, nack1 = 0, c0_at_c1 = 0;
   int strobe_cyc = 0, ack_cyc = 0, req_cyc = 0, rdy_rise_cyc = 0;
   logic prev_strb = 1'b0;

   // controller model knobs
   logic        ctl_hold = 1'b1;
   logic        ctl_hit = 1'b1;
   int          ctl_busy = 0;
   logic [15:0] ctl_data = '0;
   int          busy_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Controller: a hit keeps ready high and just presents data; a miss drops ready for ctl_busy cycles.
   always @(posedge clk) begin
      logic strobe;
      strobe = sd_rd | sd_we;
      #1;
      if (ctl_hold) begin
         sd_ready  = 1'b0;
         busy_left = 0;
      end else if (strobe && !reset) begin
         if (ctl_hit) sd_dout = ctl_data;
         else begin
            sd_ready  = 1'b0;
            busy_left = ctl_busy;
         end
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            sd_dout      = ctl_data;
            sd_ready     = 1'b1;
            rdy_rise_cyc = cyc;
         end
      end else if (!sd_ready) begin
         sd_ready     = 1'b1;
         rdy_rise_cyc = cyc;
      end
   end

   // Monitor: pops the scoreboard whenever a strobe or an ack appears.
   always @(negedge clk) begin
      strb_t es;
      ack_t  ea;
      if (reset) prev_strb = 1'b0;
      else begin
         if (sd_rd || sd_we) begin
            chk("strobe_onehot", 32'(sd_rd & sd_we), 0);
            chk("strobe_one_cycle", 32'(prev_strb), 0);
            if (strb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_strobe: addr %0h", sd_addr);
            end else begin
               es = strb_q.pop_front();
               chk("strobe_we", 32'(sd_we), 32'(es.we));
               chk("sd_addr", 32'(sd_addr), 32'(es.addr));
               chk("sd_din", 32'(sd_din), 32'(es.din));
               chk("sd_wtbt", 32'(sd_wtbt), 32'(es.wtbt));
            end
            nstrobe++;
            strobe_cyc = cyc;
         end
         prev_strb = sd_rd | sd_we;
         if (c0_ack || c1_ack) begin
            chk("ack_onehot", 32'(c0_ack & c1_ack), 0);
            if (ack_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack: c0 %0b c1 %0b", c0_ack, c1_ack);
            end else begin
               ea = ack_q.pop_front();
               chk("ack_client", 32'(c1_ack), 32'(ea.cli));
               if (ea.rd) chk("rdata", 32'(c1_ack ? c1_rdata : c0_rdata), 32'(ea.data));
            end
            if (c1_ack) begin
               nack1++;
               c0_at_c1 = nack0;
            end else nack0++;
            ack_cyc = cyc;
         end
      end
   end

   task automatic push_exp(input logic cli, input logic we, input logic [23:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
      strb_q.push_back('{we, addr, cli ? data : 16'h0, cli ? be : 2'b11});
      ack_q.push_back('{cli, data, !we});
   endtask

   task automatic wait_ack(input logic cli, input int target);
      int n = 0;
      while ((cli ? nack1 : nack0) < target && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL ack_timeout: client %0d acks %0d need %0d", cli, cli ? nack1 : nack0, target);
      end
      if (cli) c1_req = 1'b0;
      else     c0_req = 1'b0;
   endtask

   task automatic xfer(input logic cli, input logic we, input logic [23:0] addr,
                       input logic [15:0] data, input logic [1:0] be, input logic hit, input int busy);
      int t;
      ctl_hit = hit; ctl_busy = busy; ctl_data = data;
      push_exp(cli, we, addr, data, be);
      @(posedge clk); #1;
      req_cyc = cyc;
      if (cli) begin
         c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = data; c1_be = be;
      end else begin
         c0_req = 1'b1; c0_addr = addr;
      end
      t = cli ? nack1 + 1 : nack0 + 1;
      wait_ack(cli, t);
   endtask

   initial begin
      int t0, t1, ns0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sd_we", 32'(sd_we), 0);
      chk("rst_sd_rd", 32'(sd_rd), 0);
      chk("rst_acks", 32'({c0_ack, c1_ack}), 0);
      chk("rst_sd_addr", 32'(sd_addr), 0);
      chk("rst_sd_din_wtbt", 32'({sd_din, sd_wtbt}), 0);
      chk("rst_rdata", 32'({c0_rdata, c1_rdata}), 0);
      chk("rst_err", 32'(err), 0);
      reset = 1'b0;

      // startup: ready held low, request pending, nothing issued
      ctl_hit = 1'b1; ctl_data = 16'h5A5A;
      push_exp(1'b0, 1'b0, 24'h00ABCD, 16'h5A5A, 2'b11);
      c0_addr = 24'h00ABCD; c0_req = 1'b1;
      repeat (100) @(negedge clk);
      chk("startup_no_strobe", 32'(nstrobe), 0);
      ctl_hold = 1'b0;
      wait_ack(1'b0, 1);
      chk("startup_strobe_to_ack", 32'(ack_cyc - strobe_cyc), 2);

      xfer(1'b1, 1'b1, 24'h000123, 16'hBEEF, 2'b01, 1'b0, 3);
      chk("wr_ack_after_ready", 32'(ack_cyc - rdy_rise_cyc), 1);

      xfer(1'b0, 1'b0, 24'h000456, 16'h1234, 2'b11, 1'b1, 0);
      chk("hit_req_to_ack", 32'(ack_cyc - req_cyc + 1), 4);
      chk("hit_strobe_to_ack", 32'(ack_cyc - strobe_cyc), 2);

      xfer(1'b1, 1'b0, 24'h000777, 16'hCAFE, 2'b11, 1'b0, 5);
      chk("rd_miss_ack_after_ready", 32'(ack_cyc - rdy_rise_cyc), 1);

      // write with ready left high must not take the hit shortcut
      xfer(1'b1, 1'b1, 24'h000888, 16'h00FF, 2'b10, 1'b1, 0);
      chk("wr_hit_strobe_to_ack", 32'(ack_cyc - strobe_cyc), 3);

      // simultaneous requests: client 0 first
      ctl_hit = 1'b1; ctl_data = 16'h7777;
      push_exp(1'b0, 1'b0, 24'h000AAA, 16'h7777, 2'b11);
      push_exp(1'b1, 1'b1, 24'h000BBB, 16'h2222, 2'b11);
      @(posedge clk); #1;
      c0_req = 1'b1; c0_addr = 24'h000AAA;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 24'h000BBB; c1_wdata = 16'h2222; c1_be = 2'b11;
      t0 = nack0 + 1; t1 = nack1 + 1;
      fork
         wait_ack(1'b0, t0);
         wait_ack(1'b1, t1);
      join

      // starvation: client 1 slips in after four client-0 grants
      ctl_data = 16'h0C0C;
      for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 24'h000C0C, 16'h0C0C, 2'b11);
      push_exp(1'b1, 1'b1, 24'h000D0D, 16'h3333, 2'b11);
      push_exp(1'b0, 1'b0, 24'h000C0C, 16'h0C0C, 2'b11);
      @(posedge clk); #1;
      t0 = nack0; t1 = nack1 + 1;
      c0_req = 1'b1; c0_addr = 24'h000C0C;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 24'h000D0D; c1_wdata = 16'h3333; c1_be = 2'b11;
      fork
         wait_ack(1'b0, t0 + 5);
         wait_ack(1'b1, t1);
      join
      chk("starve_c0_grants", 32'(c0_at_c1 - t0), 4);

      // reset while waiting on a stalled controller
      ctl_hit = 1'b0; ctl_busy = 100000; ctl_data = 16'h4444;
      strb_q.push_back('{1'b0, 24'h000E0E, 16'h4444, 2'b11});
      ns0 = nstrobe;
      @(posedge clk); #1;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 24'h000E0E; c1_wdata = 16'h4444; c1_be = 2'b11;
      repeat (8) @(negedge clk);
      chk("wait_strobe_issued", 32'(nstrobe - ns0), 1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_strobes", 32'({sd_we, sd_rd}), 0);
      chk("midrst_acks", 32'({c0_ack, c1_ack}), 0);
      chk("midrst_sd_addr", 32'(sd_addr), 0);
      c1_req = 1'b0; ctl_hold = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0; ctl_hold = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle", 32'(nstrobe - ns0), 1);
      xfer(1'b0, 1'b0, 24'h000F0F, 16'h9999, 2'b11, 1'b1, 0);
      chk("post_rst_req_to_ack", 32'(ack_cyc - req_cyc + 1), 4);

      repeat (5) @(negedge clk);
      chk("strobe_q_empty", 32'(strb_q.size()), 0);
      chk("ack_q_empty", 32'(ack_q.size()), 0);
      chk("err_low", 32'(err), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: run did not finish, errors %0d checks %0d", errors, checks);
      $fatal(1);
   end

endmodule
